// File: rtl/mprj_bram_wb_if.sv
// rtl/mprj_bram_wb_if.sv - Wishbone slave bus bundle for the user-project BRAM
interface mprj_bram_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mprj_bram_wb.sv
// rtl/mprj_bram_wb.sv - Wishbone BRAM slave with programmable wait states before ack
// Optional next-word read buffer enabled by MPRJ_BRAM_PREFETCH_EN.
module mprj_bram_wb #(
  parameter logic [31:0] BASE_ADR = 32'h3800_0000,
  parameter int          ADDR_W   = 10,
  parameter int          DELAYS   = 10
) (
  input  logic           clock,
  input  logic           resetb,
  mprj_bram_wb_if.slave  wbs,
  output logic           la_busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [7:0] DELAY_CNT = 8'(DELAYS);

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic                lat_we;
  logic [3:0]          lat_sel;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_dat;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic                hit, req, pf_hit;
  logic [ADDR_W-1:0]   idx;
  logic [31:0]         rd_word;
  logic                unused_adr;

  assign hit        = (wbs.wbs_adr_i[31:24] == BASE_ADR[31:24]);
  assign req        = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit;
  assign idx        = wbs.wbs_adr_i[ADDR_W+1:2];
  assign unused_adr = &{1'b0, wbs.wbs_adr_i[23:ADDR_W+2], wbs.wbs_adr_i[1:0]};

`ifdef MPRJ_BRAM_PREFETCH_EN
  logic                lat_pf;
  logic                pf_valid;
  logic [ADDR_W-1:0]   pf_idx;
  logic [31:0]         pf_data;

  assign pf_hit  = pf_valid & ~wbs.wbs_we_i & (idx == pf_idx);
  assign rd_word = lat_pf ? pf_data : mem[lat_idx];

  // Buffer the word after every completed read; any completed write invalidates it.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      lat_pf   <= 1'b0;
      pf_valid <= 1'b0;
      pf_idx   <= '0;
      pf_data  <= '0;
    end else begin
      if (state == IDLE && req)
        lat_pf <= pf_hit;
      if (state == ACK) begin
        if (lat_we) begin
          pf_valid <= 1'b0;
        end else begin
          pf_valid <= 1'b1;
          pf_idx   <= lat_idx + 1'b1;
          pf_data  <= mem[lat_idx + 1'b1];
        end
      end
    end
  end
`else
  assign pf_hit  = 1'b0;
  assign rd_word = mem[lat_idx];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT: begin
        if (!wbs.wbs_cyc_i)     state_nxt = IDLE;
        else if (cnt == 8'd0)   state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      lat_we        <= 1'b0;
      lat_sel       <= 4'd0;
      lat_idx       <= '0;
      lat_dat       <= 32'd0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= 32'd0;
      la_busy_o     <= 1'b0;
    end else begin
      state         <= state_nxt;
      wbs.wbs_ack_o <= (state_nxt == ACK);
      la_busy_o     <= (state_nxt != IDLE);
      if (state == IDLE && req) begin
        // A buffered read still passes through WAIT once so ack stays registered.
        cnt     <= pf_hit ? 8'd0 : DELAY_CNT;
        lat_we  <= wbs.wbs_we_i;
        lat_sel <= wbs.wbs_sel_i;
        lat_idx <= idx;
        lat_dat <= wbs.wbs_dat_i;
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (state == WAIT && state_nxt == ACK && !lat_we)
        wbs.wbs_dat_o <= rd_word;
    end
  end

  // Array has no reset so contents survive resetb.
  always_ff @(posedge clock) begin
    if (state == ACK && lat_we) begin
      for (int b = 0; b < 4; b++)
        if (lat_sel[b]) mem[lat_idx][8*b +: 8] <= lat_dat[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_mprj_bram_wb.sv
// tb/tb_mprj_bram_wb.sv - directed self-checking bench for mprj_bram_wb
module tb_mprj_bram_wb;
  localparam int D = 10;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic la_busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  mprj_bram_wb_if bus ();

  mprj_bram_wb #(.BASE_ADR(32'h3800_0000), .ADDR_W(10), .DELAYS(D)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs       (bus),
    .la_busy_o (la_busy)
  );

  always #5 clock = ~clock;

  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    @(negedge clock);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
  endtask

  // lat = cycles from the sampling edge to the cycle in which ack is seen high.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic got, output logic [31:0] rd,
                      output int lat);
    int j;
    got = 1'b0;
    rd  = 32'h0;
    lat = -1;
    start_req(we, adr, dat, sel);
    for (j = 1; j <= 300; j++) begin
      @(negedge clock);
      if (bus.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        rd  = bus.wbs_dat_o;
        lat = j - 1;
        break;
      end
    end
    idle_bus();
  endtask

  task automatic test_reset();
    int acks;
    idle_bus();
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", bus.wbs_ack_o); end
    n_cmp++; if (bus.wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat got %h want 0", bus.wbs_dat_o); end
    n_cmp++; if (la_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", la_busy); end
    resetb = 1'b1;
    acks = 0;
    repeat (5) begin @(negedge clock); if (bus.wbs_ack_o !== 1'b0) acks++; end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL idle_no_ack got %0d acks want 0", acks); end
    start_req(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    acks = 0;
    repeat (20) begin @(negedge clock); if (bus.wbs_ack_o !== 1'b0 || la_busy !== 1'b0) acks++; end
    idle_bus();
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL nonhit_ignored got %0d busy/ack cycles want 0", acks); end
  endtask

  task automatic test_write_read();
    logic got; logic [31:0] rd; int lat;
    xfer(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, got, rd, lat);
    n_cmp++; if (got !== 1'b1 || lat != D + 1) begin n_bad++; $display("FAIL wr_latency got ack=%b lat=%0d want 1/%0d", got, lat, D + 1); end
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (got !== 1'b1 || lat != D + 1) begin n_bad++; $display("FAIL rd_latency got ack=%b lat=%0d want 1/%0d", got, lat, D + 1); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", rd); end
    @(negedge clock);
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL ack_one_cycle got %b want 0", bus.wbs_ack_o); end
    n_cmp++; if (bus.wbs_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL dat_hold got %h want deadbeef", bus.wbs_dat_o); end
  endtask

  task automatic test_byte_write();
    logic got; logic [31:0] rd; int lat;
    xfer(1'b1, 32'h3800_0010, 32'h0000_AB00, 4'b0010, got, rd, lat);
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (rd !== 32'hDEAD_ABEF) begin n_bad++; $display("FAIL byte_lane got %h want deadabef", rd); end
    xfer(1'b1, 32'h3800_0010, 32'hFFFF_FFFF, 4'b0000, got, rd, lat);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL sel0_acked got %b want 1", got); end
    xfer(1'b0, 32'h3800_1013, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (rd !== 32'hDEAD_ABEF) begin n_bad++; $display("FAIL sel0_alias got %h want deadabef", rd); end
  endtask

  task automatic test_abort();
    logic got; logic [31:0] rd; int lat; int acks;
    xfer(1'b1, 32'h3800_0014, 32'h1234_5678, 4'hF, got, rd, lat);
    start_req(1'b0, 32'h3800_0014, 32'h0, 4'hF);
    repeat (3) @(negedge clock);
    n_cmp++; if (la_busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_wait got %b want 1", la_busy); end
    idle_bus();
    @(negedge clock);
    n_cmp++; if (la_busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle got %b want 0", la_busy); end
    acks = 0;
    repeat (20) begin @(negedge clock); if (bus.wbs_ack_o !== 1'b0) acks++; end
    n_cmp++; if (acks != 0 || bus.wbs_dat_o !== 32'hDEAD_ABEF) begin n_bad++; $display("FAIL rd_abort got acks=%0d dat=%h want 0/deadabef", acks, bus.wbs_dat_o); end
    start_req(1'b1, 32'h3800_0014, 32'hFFFF_FFFF, 4'hF);
    repeat (3) @(negedge clock);
    idle_bus();
    acks = 0;
    repeat (20) begin @(negedge clock); if (bus.wbs_ack_o !== 1'b0) acks++; end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL wr_abort_ack got %0d want 0", acks); end
    xfer(1'b0, 32'h3800_0014, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_abort_mem got %h want 12345678", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic got; logic [31:0] rd; int lat; int acks;
    start_req(1'b0, 32'h3800_0010, 32'h0, 4'hF);
    repeat (3) @(negedge clock);
    resetb = 1'b0;
    idle_bus();
    #1;
    n_cmp++; if (la_busy !== 1'b0 || bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL async_reset got busy=%b ack=%b dat=%h want 0/0/0", la_busy, bus.wbs_ack_o, bus.wbs_dat_o); end
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    acks = 0;
    repeat (15) begin @(negedge clock); if (bus.wbs_ack_o !== 1'b0 || la_busy !== 1'b0) acks++; end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL reset_no_ack got %0d want 0", acks); end
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (rd !== 32'hDEAD_ABEF) begin n_bad++; $display("FAIL mem_survive0 got %h want deadabef", rd); end
    xfer(1'b0, 32'h3800_0014, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL mem_survive1 got %h want 12345678", rd); end
  endtask

  task automatic test_prefetch();
    logic got; logic [31:0] rd; int lat; int fast;
`ifdef MPRJ_BRAM_PREFETCH_EN
    fast = 1;
`else
    fast = D + 1;
`endif
    xfer(1'b1, 32'h3800_0000, 32'hA5A5_0000, 4'hF, got, rd, lat);
    xfer(1'b1, 32'h3800_0004, 32'h1111_1111, 4'hF, got, rd, lat);
    xfer(1'b1, 32'h3800_0FFC, 32'h0000_03FF, 4'hF, got, rd, lat);
    xfer(1'b0, 32'h3800_0FFC, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (lat != D + 1 || rd !== 32'h0000_03FF) begin n_bad++; $display("FAIL pf_first got lat=%0d dat=%h want %0d/000003ff", lat, rd, D + 1); end
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (lat != fast || rd !== 32'hA5A5_0000) begin n_bad++; $display("FAIL pf_wrap got lat=%0d dat=%h want %0d/a5a50000", lat, rd, fast); end
    xfer(1'b1, 32'h3800_001C, 32'h0000_0077, 4'hF, got, rd, lat);
    xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (lat != D + 1 || rd !== 32'h1111_1111) begin n_bad++; $display("FAIL pf_inval got lat=%0d dat=%h want %0d/11111111", lat, rd, D + 1); end
  endtask

  task automatic test_back_to_back();
    logic got; logic [31:0] rd; int lat; int fast;
`ifdef MPRJ_BRAM_PREFETCH_EN
    fast = 1;
`else
    fast = D + 1;
`endif
    xfer(1'b1, 32'h3800_0020, 32'hCAFE_0008, 4'hF, got, rd, lat);
    xfer(1'b1, 32'h3800_0024, 32'hCAFE_0009, 4'hF, got, rd, lat);
    xfer(1'b0, 32'h3800_0020, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (lat != D + 1 || rd !== 32'hCAFE_0008) begin n_bad++; $display("FAIL b2b_first got lat=%0d dat=%h want %0d/cafe0008", lat, rd, D + 1); end
    xfer(1'b0, 32'h3800_0024, 32'h0, 4'hF, got, rd, lat);
    n_cmp++; if (lat != fast || rd !== 32'hCAFE_0009) begin n_bad++; $display("FAIL b2b_second got lat=%0d dat=%h want %0d/cafe0009", lat, rd, fast); end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_write_read();
    test_byte_write();
    test_abort();
    test_reset_mid_wait();
    test_prefetch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
